// File: rtl/ram_vector_alu_if.sv
// Command, RAM-port and status bundle between the vector ALU and its environment.
// Ports: command (start/op/src_a/src_b/dst/length), RAM read data in, RAM read/write addresses,
//        write enable/data out, and busy/done/overflow status out. _i/_o are seen from the ALU.
interface ram_vector_alu_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                         start_i;
    logic [1:0]                   op_i;
    logic [ADDR_WIDTH-1:0]        src_a_i;
    logic [ADDR_WIDTH-1:0]        src_b_i;
    logic [ADDR_WIDTH-1:0]        dst_i;
    logic [ADDR_WIDTH-1:0]        length_i;
    logic signed [DATA_WIDTH-1:0] rd_data0_i;
    logic signed [DATA_WIDTH-1:0] rd_data1_i;
    logic [ADDR_WIDTH-1:0]        rd_addr0_o;
    logic [ADDR_WIDTH-1:0]        rd_addr1_o;
    logic                         wr_en_o;
    logic [ADDR_WIDTH-1:0]        wr_addr_o;
    logic signed [DATA_WIDTH-1:0] wr_data_o;
    logic                         busy_o;
    logic                         done_o;
    logic                         overflow_o;

    // The ALU itself.
    modport slave (
        input  start_i, op_i, src_a_i, src_b_i, dst_i, length_i, rd_data0_i, rd_data1_i,
        output rd_addr0_o, rd_addr1_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, overflow_o
    );

    // Sequencer plus RAM: issues commands, returns read data, consumes writes.
    modport master (
        output start_i, op_i, src_a_i, src_b_i, dst_i, length_i, rd_data0_i, rd_data1_i,
        input  rd_addr0_o, rd_addr1_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, overflow_o
    );
endinterface

// File: rtl/ram_vector_alu.sv
// Vector execute stage behind a dual-read/single-write RAM: saturating ADD/SUB, fixed-point MUL, MAC.
// Ports: clk, rst (async, active high), bus (ram_vector_alu_if.slave: command, RAM ports, status).
// Latency start->done: 3N+1 (ADD/SUB/MUL), 2N+2 (MAC), 1 (N=0); start is ignored while busy.
module ram_vector_alu #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAC_BITS  = 8
) (
    input  logic            clk,
    input  logic            rst,
    ram_vector_alu_if.slave bus
);
    localparam int PRD_W = 2 * DATA_WIDTH;
    // Wide enough for 2^ADDR_WIDTH full-scale products, so the MAC accumulator cannot wrap.
    localparam int ACC_W = 2 * DATA_WIDTH + ADDR_WIDTH;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                       state_q;
    logic [1:0]                   op_q;
    logic [ADDR_WIDTH-1:0]        src_a_q;
    logic [ADDR_WIDTH-1:0]        src_b_q;
    logic [ADDR_WIDTH-1:0]        dst_q;
    logic [ADDR_WIDTH-1:0]        len_q;
    logic [ADDR_WIDTH-1:0]        k_q;
    logic signed [ACC_W-1:0]      acc_q;
    logic [ADDR_WIDTH-1:0]        rd_addr0_q;
    logic [ADDR_WIDTH-1:0]        rd_addr1_q;
    logic                         we_q;
    logic [ADDR_WIDTH-1:0]        wr_addr_q;
    logic signed [DATA_WIDTH-1:0] wr_data_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         ovf_q;

    logic [ADDR_WIDTH-1:0]        k_next;
    logic                         last_elem;
    logic signed [PRD_W-1:0]      a_w;
    logic signed [PRD_W-1:0]      b_w;
    logic signed [PRD_W-1:0]      prod;
    logic signed [ACC_W-1:0]      a_x;
    logic signed [ACC_W-1:0]      b_x;
    logic signed [ACC_W-1:0]      prod_x;
    logic signed [ACC_W-1:0]      acc_d;
    logic signed [ACC_W-1:0]      wide_d;
    logic [ACC_W-DATA_WIDTH:0]    top_bits;
    logic                         sat_d;
    logic signed [DATA_WIDTH-1:0] result_d;

    // Datapath: every op is first formed exactly in ACC_W bits, then one shared saturator
    // clamps it to DATA_WIDTH.
    always_comb begin
        k_next    = k_q + ADDR_WIDTH'(1);
        last_elem = (k_next == len_q);

        // Operands widened to 2W before the multiply so the low 2W product bits are exact.
        a_w    = {{DATA_WIDTH{bus.rd_data0_i[DATA_WIDTH-1]}}, bus.rd_data0_i};
        b_w    = {{DATA_WIDTH{bus.rd_data1_i[DATA_WIDTH-1]}}, bus.rd_data1_i};
        prod   = a_w * b_w;
        a_x    = {{(ACC_W-DATA_WIDTH){bus.rd_data0_i[DATA_WIDTH-1]}}, bus.rd_data0_i};
        b_x    = {{(ACC_W-DATA_WIDTH){bus.rd_data1_i[DATA_WIDTH-1]}}, bus.rd_data1_i};
        prod_x = {{(ACC_W-PRD_W){prod[PRD_W-1]}}, prod};
        acc_d  = acc_q + prod_x;

        wide_d = a_x + b_x;
        case (op_q)
            OP_ADD:  wide_d = a_x + b_x;
            OP_SUB:  wide_d = a_x - b_x;
            OP_MUL:  wide_d = prod_x >>> FRAC_BITS;
            default: wide_d = acc_d >>> FRAC_BITS;   // MAC: scaled running sum incl. this element
        endcase

        // Value fits in DATA_WIDTH iff all bits from the result sign bit upward agree.
        top_bits = wide_d[ACC_W-1:DATA_WIDTH-1];
        sat_d    = !((&top_bits) || !(|top_bits));
        result_d = wide_d[DATA_WIDTH-1:0];
        if (sat_d) begin
            result_d = wide_d[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            rd_addr0_q <= '0;
            rd_addr1_q <= '0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    we_q   <= 1'b0;
                    if (bus.start_i) begin
                        op_q       <= bus.op_i;
                        src_a_q    <= bus.src_a_i;
                        src_b_q    <= bus.src_b_i;
                        dst_q      <= bus.dst_i;
                        len_q      <= bus.length_i;
                        k_q        <= '0;
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        rd_addr0_q <= bus.src_a_i;
                        rd_addr1_q <= bus.src_b_i;
                        if (bus.length_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                // Addresses are already on the RAM; it captures the data at the end of this cycle.
                S_FETCH: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_q == OP_MAC) begin
                        acc_q <= acc_d;
                        k_q   <= k_next;
                        if (last_elem) begin
                            wr_data_q <= result_d;
                            wr_addr_q <= dst_q;
                            we_q      <= 1'b1;
                            ovf_q     <= ovf_q | sat_d;
                            state_q   <= S_WRITE;
                        end else begin
                            rd_addr0_q <= src_a_q + k_next;
                            rd_addr1_q <= src_b_q + k_next;
                            state_q    <= S_FETCH;
                        end
                    end else begin
                        wr_data_q <= result_d;
                        wr_addr_q <= dst_q + k_q;
                        we_q      <= 1'b1;
                        ovf_q     <= ovf_q | sat_d;
                        state_q   <= S_WRITE;
                    end
                end
                // The write lands at the end of this cycle, before the next element is fetched,
                // which keeps in-place and overlapping vectors correct.
                S_WRITE: begin
                    we_q <= 1'b0;
                    if (op_q == OP_MAC) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        k_q <= k_next;
                        if (last_elem) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            rd_addr0_q <= src_a_q + k_next;
                            rd_addr1_q <= src_b_q + k_next;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_addr0_o = rd_addr0_q;
    assign bus.rd_addr1_o = rd_addr1_q;
    assign bus.wr_en_o    = we_q;
    assign bus.wr_addr_o  = wr_addr_q;
    assign bus.wr_data_o  = wr_data_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_ram_vector_alu.sv
// Bench for ram_vector_alu: behavioural RAM plus a plain-arithmetic reference model of each command.
module tb_ram_vector_alu;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int FB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_vector_alu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    ram_vector_alu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAC_BITS(FB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM: registered read data, write at the clock edge; preload copies pre[] in one cycle.
    logic signed [DW-1:0] mem [256];
    logic signed [DW-1:0] pre [256];
    logic                 load = 1'b0;
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= pre[i];
        end else if (bus.wr_en_o) begin
            mem[bus.wr_addr_o] <= bus.wr_data_o;
        end
        bus.rd_data0_i <= mem[bus.rd_addr0_o];
        bus.rd_data1_i <= mem[bus.rd_addr1_o];
    end

    int checks   = 0;
    int failures = 0;
    logic signed [DW-1:0] exp_mem [256];
    bit model_ovf;

    function automatic logic signed [DW-1:0] sat(input longint v);
        if (v > 32767)  begin model_ovf = 1'b1; return 16'sh7FFF; end
        if (v < -32768) begin model_ovf = 1'b1; return 16'sh8000; end
        return v[15:0];
    endfunction

    // Reference: elements processed strictly in order against the model memory.
    task automatic model_cmd(input logic [1:0] op, input logic [7:0] sa, sb, dst, n);
        logic [7:0] ia, ib, id;
        longint a, b, acc;
        model_ovf = 1'b0;
        acc = 0;
        for (int k = 0; k < int'(n); k++) begin
            ia = sa + 8'(k);
            ib = sb + 8'(k);
            id = dst + 8'(k);
            a = longint'(exp_mem[ia]);
            b = longint'(exp_mem[ib]);
            case (op)
                2'd0: exp_mem[id] = sat(a + b);
                2'd1: exp_mem[id] = sat(a - b);
                2'd2: exp_mem[id] = sat((a * b) >>> 8);
                default: acc = acc + a * b;
            endcase
        end
        if (op == 2'd3 && n != 8'd0) exp_mem[dst] = sat(acc >>> 8);
    endtask

    task automatic load_mem();
        @(negedge clk);
        for (int i = 0; i < 256; i++) pre[i] = exp_mem[i];
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Issues one command and watches it to completion; lat is the cycle of done after the start edge.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] sa, sb, dst, n, input bit poke,
                          output int lat, output int writes);
        @(negedge clk);
        bus.op_i = op; bus.src_a_i = sa; bus.src_b_i = sb; bus.dst_i = dst; bus.length_i = n;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        lat = -1;
        writes = 0;
        for (int c = 1; c <= 1000; c++) begin
            if (bus.wr_en_o === 1'b1) writes++;
            if (poke && c == 2) begin
                bus.start_i = 1'b1; bus.op_i = ~op; bus.dst_i = dst + 8'd100; bus.length_i = 8'd7;
            end
            if (poke && c == 3) bus.start_i = 1'b0;
            if (bus.done_o === 1'b1) begin lat = c; break; end
            @(negedge clk);
        end
        bus.start_i = 1'b0;
    endtask

    function automatic logic signed [DW-1:0] rnd_word();
        logic [15:0] r;
        case ($urandom_range(0, 2))
            0:       r = 16'($urandom);
            1:       r = 16'($urandom_range(0, 1023)) - 16'd512;
            default: r = ($urandom_range(0, 1) != 0) ? 16'h7F00 + 16'($urandom_range(0, 255))
                                                     : 16'h8000 + 16'($urandom_range(0, 255));
        endcase
        return signed'(r);
    endfunction

    task automatic test_reset();
        bus.start_i = 1'b0; bus.op_i = 2'd0; bus.src_a_i = '0; bus.src_b_i = '0;
        bus.dst_i = '0; bus.length_i = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.wr_en_o !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b want 0", bus.overflow_o); end
        checks++; if (bus.rd_addr0_o !== 8'd0 || bus.wr_addr_o !== 8'd0 || bus.wr_data_o !== 16'sd0) begin
            failures++; $display("FAIL reset_addr got ra0=%h wa=%h wd=%h want 0", bus.rd_addr0_o, bus.wr_addr_o, bus.wr_data_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = 16'sd0;
        load_mem();
    endtask

    task automatic test_add_saturate();
        int lat, wr;
        exp_mem[10] = 16'sd100; exp_mem[11] = 16'sd32767; exp_mem[12] = -16'sd5;
        exp_mem[20] = 16'sd20;  exp_mem[21] = 16'sd1;     exp_mem[22] = -16'sd7;
        load_mem();
        do_cmd(2'd0, 8'd10, 8'd20, 8'd30, 8'd3, 1'b0, lat, wr);
        model_cmd(2'd0, 8'd10, 8'd20, 8'd30, 8'd3);
        checks++; if (lat !== 10) begin failures++; $display("FAIL add_latency got %0d want 10", lat); end
        checks++; if (wr !== 3) begin failures++; $display("FAIL add_writes got %0d want 3", wr); end
        checks++; if (mem[30] !== 16'sd120 || mem[31] !== 16'sd32767 || mem[32] !== -16'sd12) begin
            failures++; $display("FAIL add_data got %0d %0d %0d want 120 32767 -12", mem[30], mem[31], mem[32]);
        end
        checks++; if (bus.overflow_o !== 1'b1) begin failures++; $display("FAIL add_ovf got %b want 1", bus.overflow_o); end
        repeat (3) @(negedge clk);
        checks++; if (bus.overflow_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            failures++; $display("FAIL add_ovf_sticky got ovf=%b busy=%b want 1 0", bus.overflow_o, bus.busy_o);
        end
    endtask

    task automatic test_mul();
        int lat, wr;
        exp_mem[40] = 16'sh0180; exp_mem[41] = 16'shFE80;
        exp_mem[50] = 16'sh0200; exp_mem[51] = 16'sh0200;
        load_mem();
        do_cmd(2'd2, 8'd40, 8'd50, 8'd60, 8'd2, 1'b0, lat, wr);
        model_cmd(2'd2, 8'd40, 8'd50, 8'd60, 8'd2);
        checks++; if (mem[60] !== 16'sh0300 || mem[61] !== 16'shFD00) begin
            failures++; $display("FAIL mul_data got %h %h want 0300 fd00", mem[60], mem[61]);
        end
        checks++; if (bus.overflow_o !== 1'b0) begin failures++; $display("FAIL mul_ovf got %b want 0", bus.overflow_o); end
        checks++; if (lat !== 7 || wr !== 2) begin failures++; $display("FAIL mul_timing got lat=%0d wr=%0d want 7 2", lat, wr); end
    endtask

    task automatic test_mac();
        int lat, wr;
        for (int i = 0; i < 4; i++) begin exp_mem[70+i] = 16'sh0100; exp_mem[80+i] = 16'sh0200; end
        exp_mem[91] = 16'sd1234;
        load_mem();
        do_cmd(2'd3, 8'd70, 8'd80, 8'd90, 8'd4, 1'b0, lat, wr);
        model_cmd(2'd3, 8'd70, 8'd80, 8'd90, 8'd4);
        checks++; if (mem[90] !== 16'sh0800 || mem[91] !== 16'sd1234) begin
            failures++; $display("FAIL mac_data got %h %h want 0800 04d2", mem[90], mem[91]);
        end
        checks++; if (lat !== 10 || wr !== 1) begin failures++; $display("FAIL mac_timing got lat=%0d wr=%0d want 10 1", lat, wr); end
    endtask

    task automatic test_zero_len_and_busy();
        int lat, wr, bad;
        for (int op = 0; op < 4; op++) begin
            do_cmd(2'(op), 8'd10, 8'd20, 8'd30, 8'd0, 1'b0, lat, wr);
            checks++; if (lat !== 1 || wr !== 0) begin
                failures++; $display("FAIL zero_len op=%0d got lat=%0d wr=%0d want 1 0", op, lat, wr);
            end
        end
        do_cmd(2'd0, 8'd10, 8'd20, 8'd160, 8'd2, 1'b1, lat, wr);
        model_cmd(2'd0, 8'd10, 8'd20, 8'd160, 8'd2);
        checks++; if (lat !== 7 || wr !== 2) begin failures++; $display("FAIL busy_ignore_timing got lat=%0d wr=%0d want 7 2", lat, wr); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL busy_ignore_mem got %0d bad words want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int lat, wr, bad;
        for (int i = 0; i < 3; i++) begin
            exp_mem[100+i] = 16'(5 + i); exp_mem[110+i] = 16'sd1; exp_mem[120+i] = 16'sd999;
        end
        load_mem();
        @(negedge clk);
        bus.op_i = 2'd0; bus.src_a_i = 8'd100; bus.src_b_i = 8'd110; bus.dst_i = 8'd120; bus.length_i = 8'd3;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);   // now in cycle 5: EXEC of element 1
        rst = 1'b1;
        #1;
        checks++; if (bus.wr_en_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            failures++; $display("FAIL reset_mid_outputs got we=%b busy=%b done=%b want 0 0 0", bus.wr_en_o, bus.busy_o, bus.done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem[120] !== 16'sd6 || mem[121] !== 16'sd999 || mem[122] !== 16'sd999) begin
            failures++; $display("FAIL reset_mid_mem got %0d %0d %0d want 6 999 999", mem[120], mem[121], mem[122]);
        end
        exp_mem[120] = 16'sd6;
        do_cmd(2'd1, 8'd100, 8'd110, 8'd120, 8'd3, 1'b0, lat, wr);
        model_cmd(2'd1, 8'd100, 8'd110, 8'd120, 8'd3);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        checks++; if (bad != 0 || lat !== 10) begin
            failures++; $display("FAIL reset_mid_recover got bad=%0d lat=%0d want 0 10", bad, lat);
        end
    endtask

    task automatic test_inplace_sub();
        int lat, wr;
        exp_mem[140] = 16'sd10; exp_mem[141] = 16'sh8000;
        exp_mem[150] = 16'sd3;  exp_mem[151] = 16'sd1;
        load_mem();
        do_cmd(2'd1, 8'd140, 8'd150, 8'd140, 8'd2, 1'b0, lat, wr);
        model_cmd(2'd1, 8'd140, 8'd150, 8'd140, 8'd2);
        checks++; if (mem[140] !== 16'sd7 || mem[141] !== 16'sh8000) begin
            failures++; $display("FAIL inplace_data got %0d %0d want 7 -32768", mem[140], mem[141]);
        end
        checks++; if (bus.overflow_o !== 1'b1 || lat !== 7) begin
            failures++; $display("FAIL inplace_ovf got ovf=%b lat=%0d want 1 7", bus.overflow_o, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, wr, bad, exp_lat, exp_wr;
        logic [1:0] op;
        logic [7:0] sa, sb, dst, n;
        for (int i = 0; i < 256; i++) exp_mem[i] = rnd_word();
        load_mem();
        for (int it = 0; it < 30; it++) begin
            op  = 2'($urandom_range(0, 3));
            sa  = 8'($urandom); sb = 8'($urandom); dst = 8'($urandom);
            n   = 8'($urandom_range(0, 12));
            if (it == 0) begin sa = 8'd250; dst = 8'd252; n = 8'd10; end
            do_cmd(op, sa, sb, dst, n, 1'b0, lat, wr);
            model_cmd(op, sa, sb, dst, n);
            exp_lat = (n == 8'd0) ? 1 : (op == 2'd3) ? 2 * int'(n) + 2 : 3 * int'(n) + 1;
            exp_wr  = (n == 8'd0) ? 0 : (op == 2'd3) ? 1 : int'(n);
            checks++; if (lat !== exp_lat || wr !== exp_wr) begin
                failures++; $display("FAIL rand_timing it=%0d op=%0d n=%0d got lat=%0d wr=%0d want %0d %0d",
                                     it, op, n, lat, wr, exp_lat, exp_wr);
            end
            checks++; if (bus.overflow_o !== model_ovf) begin
                failures++; $display("FAIL rand_ovf it=%0d op=%0d got %b want %b", it, op, bus.overflow_o, model_ovf);
            end
            bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
            checks++; if (bad != 0) begin
                failures++; $display("FAIL rand_mem it=%0d op=%0d got %0d bad words want 0", it, op, bad);
                load_mem();
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_saturate();
        test_mul();
        test_mac();
        test_zero_len_and_busy();
        test_reset_mid();
        test_inplace_sub();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
